// File: rtl/flappy_game_ctrl.sv
// Game-flow controller: Idle/Play/Dying/Over sequencing, per-pipe collision and pass scoring.
// Optional floor/ceiling death enabled by defining FLAPPY_FALL_DETECT_EN.
module flappy_game_ctrl #(
   parameter int NUM_PIPES    = 2,
   parameter int COORD_W      = 10,
   parameter int SCORE_W      = 16,
   parameter int BIRD_HALF    = 10,
   parameter int PIPE_HALF_W  = 50,
   parameter int GAP_H        = 150,
   parameter int DEATH_CYCLES = 60,
   parameter int Y_MAX        = 479
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           Start,
   input  logic                           Ack,
   input  logic [COORD_W-1:0]             XBird,
   input  logic [COORD_W-1:0]             YBird,
   input  logic [NUM_PIPES*COORD_W-1:0]   XPipe,
   input  logic [NUM_PIPES*COORD_W-1:0]   YPipe,
   output logic                           q_Idle,
   output logic                           q_Play,
   output logic                           q_Dying,
   output logic                           q_Over,
   output logic                           collide,
   output logic [SCORE_W-1:0]             score,
   output logic [SCORE_W-1:0]             high_score,
   output logic                           new_high
);
   localparam int EXT_W = COORD_W + 2;
   localparam int CNT_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
   localparam int POP_W = $clog2(NUM_PIPES + 1);
   localparam int SUM_W = SCORE_W + POP_W;

   localparam logic [EXT_W-1:0] BH   = EXT_W'(BIRD_HALF);
   localparam logic [EXT_W-1:0] PHW  = EXT_W'(PIPE_HALF_W);
   localparam logic [EXT_W-1:0] GH   = EXT_W'(GAP_H);
   localparam logic [EXT_W-1:0] YMX  = EXT_W'(Y_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEATH_CYCLES - 1);
   localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

`ifdef FLAPPY_FALL_DETECT_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   // One-hot encoding so each state flag is a flop bit directly
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_PLAY  = 4'b0010,
      S_DYING = 4'b0100,
      S_OVER  = 4'b1000
   } state_t;

   state_t               state_reg;
   logic [CNT_W-1:0]     death_cnt_reg;
   logic [NUM_PIPES-1:0] flag_reg;
   logic [SCORE_W-1:0]   score_reg;
   logic [SCORE_W-1:0]   high_reg;
   logic                 collide_reg;
   logic                 new_high_reg;

   logic [NUM_PIPES-1:0] hit_vec;
   logic [NUM_PIPES-1:0] passed_vec;
   logic [EXT_W-1:0]     xb;
   logic [EXT_W-1:0]     yb;
   logic                 fall_hit;
   logic                 hit_any;
   logic [POP_W-1:0]     new_cnt;
   logic [SUM_W-1:0]     sum;
   logic [SCORE_W-1:0]   score_next;

   assign xb = EXT_W'(XBird);
   assign yb = EXT_W'(YBird);

   generate
      for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
         logic [EXT_W-1:0] xp;
         logic [EXT_W-1:0] yp;
         logic             h_ovl;
         logic             v_miss;
         assign xp     = EXT_W'(XPipe[gi*COORD_W +: COORD_W]);
         assign yp     = EXT_W'(YPipe[gi*COORD_W +: COORD_W]);
         assign h_ovl  = (xb + BH + PHW > xp) && (xb < xp + PHW + BH);
         assign v_miss = (yb < yp + BH) || (yb + BH > yp + GH);
         assign hit_vec[gi]    = h_ovl && v_miss;
         assign passed_vec[gi] = (xb >= xp);
      end
   endgenerate

   assign fall_hit = FALL_EN && ((yb + BH >= YMX) || (yb < BH));
   assign hit_any  = (|hit_vec) || fall_hit;

   // A pass counts only on the cycle the bird first crosses the pipe centre
   always_comb begin
      new_cnt = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         new_cnt = new_cnt + POP_W'(passed_vec[i] & ~flag_reg[i]);
      end
      sum        = SUM_W'(score_reg) + SUM_W'(new_cnt);
      score_next = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= S_IDLE;
         death_cnt_reg <= '0;
         flag_reg      <= '0;
         score_reg     <= '0;
         high_reg      <= '0;
         collide_reg   <= 1'b0;
         new_high_reg  <= 1'b0;
      end else begin
         collide_reg <= 1'b0;
         unique case (state_reg)
            S_IDLE: begin
               score_reg <= '0;
               if (Start) begin
                  state_reg <= S_PLAY;
                  flag_reg  <= passed_vec;
               end
            end
            S_PLAY: begin
               flag_reg <= passed_vec;
               if (hit_any) begin
                  state_reg     <= S_DYING;
                  collide_reg   <= 1'b1;
                  death_cnt_reg <= '0;
               end else begin
                  score_reg <= score_next;
               end
            end
            S_DYING: begin
               if (death_cnt_reg == CNT_LAST) begin
                  state_reg     <= S_OVER;
                  death_cnt_reg <= '0;
                  if (score_reg > high_reg) begin
                     high_reg     <= score_reg;
                     new_high_reg <= 1'b1;
                  end else begin
                     new_high_reg <= 1'b0;
                  end
               end else begin
                  death_cnt_reg <= death_cnt_reg + 1'b1;
               end
            end
            S_OVER: begin
               if (Ack) begin
                  state_reg    <= S_IDLE;
                  new_high_reg <= 1'b0;
                  score_reg    <= '0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign q_Idle     = state_reg[0];
   assign q_Play     = state_reg[1];
   assign q_Dying    = state_reg[2];
   assign q_Over     = state_reg[3];
   assign collide    = collide_reg;
   assign score      = score_reg;
   assign high_score = high_reg;
   assign new_high   = new_high_reg;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: default instance plus a 4-bit-score instance for saturation.
module tb_flappy_game_ctrl;
   localparam logic [3:0] ST_IDLE  = 4'b0001;
   localparam logic [3:0] ST_PLAY  = 4'b0010;
   localparam logic [3:0] ST_DYING = 4'b0100;
   localparam logic [3:0] ST_OVER  = 4'b1000;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0, Ack = 1'b0;
   logic [9:0]  XBird = 10'd100, YBird = 10'd200;
   logic [19:0] XPipe = {10'd900, 10'd600};
   logic [19:0] YPipe = {10'd150, 10'd150};
   logic        q_Idle, q_Play, q_Dying, q_Over, collide, new_high;
   logic [15:0] score, high_score;

   logic        Start4 = 1'b0, Ack4 = 1'b0;
   logic [9:0]  XBird4 = 10'd100, YBird4 = 10'd200;
   logic [19:0] XPipe4 = {10'd900, 10'd101};
   logic [19:0] YPipe4 = {10'd150, 10'd150};
   logic        q_Idle4, q_Play4, q_Dying4, q_Over4, collide4, new_high4;
   logic [3:0]  score4, high_score4;

   typedef struct {
      string      name;
      logic [20:0] val;
   } exp_t;
   exp_t sbq[$];
   int n_checks = 0;
   int n_err = 0;

   wire [20:0] obs  = {q_Over, q_Dying, q_Play, q_Idle, score, collide};
   wire [20:0] obs4 = {q_Over4, q_Dying4, q_Play4, q_Idle4, 12'd0, score4, collide4};

   flappy_game_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .XBird(XBird), .YBird(YBird), .XPipe(XPipe), .YPipe(YPipe),
      .q_Idle(q_Idle), .q_Play(q_Play), .q_Dying(q_Dying), .q_Over(q_Over),
      .collide(collide), .score(score), .high_score(high_score), .new_high(new_high)
   );

   flappy_game_ctrl #(.SCORE_W(4), .DEATH_CYCLES(3)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(Start4), .Ack(Ack4),
      .XBird(XBird4), .YBird(YBird4), .XPipe(XPipe4), .YPipe(YPipe4),
      .q_Idle(q_Idle4), .q_Play(q_Play4), .q_Dying(q_Dying4), .q_Over(q_Over4),
      .collide(collide4), .score(score4), .high_score(high_score4), .new_high(new_high4)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(string n, logic [3:0] st, int sc, logic c);
      exp_t e;
      e.name = n;
      e.val  = {st, 16'(sc), c};
      return e;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      n_checks++;
      if (obs !== {ST_IDLE, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got %h want %h", obs, {ST_IDLE, 16'd0, 1'b0});
      end
      n_checks++;
      if ({high_score, new_high} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_high: got high=%0d nh=%b want 0 0", high_score, new_high);
      end
      n_checks++;
      if (obs4 !== {ST_IDLE, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state4: got %h want %h", obs4, {ST_IDLE, 16'd0, 1'b0});
      end
      $display("txn reset: st=%b score=%0d", obs[20:17], score);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   // Pipe 0 sweeps past the bird inside the gap, then respawns to the right
   task automatic test_pass_scoring();
      exp_t e;
      int   xs[$];
      xs.push_back(-1);
      for (int x = 580; x >= 120; x -= 20) xs.push_back(x);
      xs.push_back(101); xs.push_back(100); xs.push_back(99); xs.push_back(700);
      foreach (xs[i]) begin
         @(negedge Clk);
         if (i == 0) begin
            Start = 1'b1;
            sbq.push_back(mk("start", ST_PLAY, 0, 1'b0));
         end else begin
            Start = 1'b0;
            XPipe[9:0] = 10'(xs[i]);
            sbq.push_back(mk($sformatf("ramp_x%0d", xs[i]), ST_PLAY,
                             (xs[i] <= 100 || xs[i] == 700) ? 1 : 0, 1'b0));
         end
         tick();
         e = sbq.pop_front();
         n_checks++;
         if (obs !== e.val) begin
            n_err++;
            $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                     e.name, obs[20:17], obs[16:1], obs[0], e.val[20:17], e.val[16:1], e.val[0]);
         end else $display("txn %s: st=%b score=%0d col=%b", e.name, obs[20:17], obs[16:1], obs[0]);
      end
   endtask

   // Hit below the gap while also crossing the pipe: collision wins, then 60 Dying cycles
   task automatic test_collision();
      exp_t e;
      for (int k = 0; k <= 61; k++) begin
         @(negedge Clk);
         if (k == 0) begin
            XPipe[9:0] = 10'd100;
            YBird = 10'd140;
         end
         Ack = (k == 61);
         if (k == 0)       sbq.push_back(mk("collide", ST_DYING, 1, 1'b1));
         else if (k < 60)  sbq.push_back(mk($sformatf("dying%0d", k), ST_DYING, 1, 1'b0));
         else if (k == 60) sbq.push_back(mk("over", ST_OVER, 1, 1'b0));
         else              sbq.push_back(mk("ack_idle", ST_IDLE, 0, 1'b0));
         tick();
         e = sbq.pop_front();
         n_checks++;
         if (obs !== e.val) begin
            n_err++;
            $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                     e.name, obs[20:17], obs[16:1], obs[0], e.val[20:17], e.val[16:1], e.val[0]);
         end else if (k == 0 || k >= 59) begin
            $display("txn %s: st=%b score=%0d col=%b", e.name, obs[20:17], obs[16:1], obs[0]);
         end
         if (k == 60 || k == 61) begin
            n_checks++;
            if (high_score !== 16'd1 || new_high !== (k == 60)) begin
               n_err++;
               $display("FAIL high_after_game1_k%0d: got high=%0d nh=%b want high=1 nh=%b",
                        k, high_score, new_high, (k == 60));
            end
         end
      end
      @(negedge Clk);
      Ack = 1'b0;
   endtask

   // Two pipes passed together, then a pass coinciding with a hit, then Start held through Ack
   task automatic test_double_pass();
      exp_t e;
      for (int k = 0; k <= 65; k++) begin
         @(negedge Clk);
         case (k)
            0: begin Start = 1'b1; XPipe = {10'd101, 10'd101}; YBird = 10'd200; end
            1: begin Start = 1'b0; Ack = 1'b1; XPipe = {10'd100, 10'd100}; end
            2: begin Ack = 1'b0; XPipe = {10'd101, 10'd101}; end
            3: begin XPipe = {10'd100, 10'd100}; YBird = 10'd140; Start = 1'b1; end
            64: begin Ack = 1'b1; Start = 1'b1; XPipe = {10'd900, 10'd101}; YBird = 10'd200; end
            65: Ack = 1'b0;
            default: ;
         endcase
         if (k == 0)       sbq.push_back(mk("dbl_start", ST_PLAY, 0, 1'b0));
         else if (k <= 2)  sbq.push_back(mk($sformatf("dbl_step%0d", k), ST_PLAY, 2, 1'b0));
         else if (k == 3)  sbq.push_back(mk("dbl_hit", ST_DYING, 2, 1'b1));
         else if (k < 63)  sbq.push_back(mk($sformatf("dbl_dying%0d", k), ST_DYING, 2, 1'b0));
         else if (k == 63) sbq.push_back(mk("dbl_over", ST_OVER, 2, 1'b0));
         else if (k == 64) sbq.push_back(mk("dbl_ack", ST_IDLE, 0, 1'b0));
         else              sbq.push_back(mk("held_start", ST_PLAY, 0, 1'b0));
         tick();
         e = sbq.pop_front();
         n_checks++;
         if (obs !== e.val) begin
            n_err++;
            $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                     e.name, obs[20:17], obs[16:1], obs[0], e.val[20:17], e.val[16:1], e.val[0]);
         end else if (k <= 3 || k >= 62) begin
            $display("txn %s: st=%b score=%0d col=%b", e.name, obs[20:17], obs[16:1], obs[0]);
         end
         if (k == 63) begin
            n_checks++;
            if (high_score !== 16'd2 || new_high !== 1'b1) begin
               n_err++;
               $display("FAIL high_after_game2: got high=%0d nh=%b want high=2 nh=1",
                        high_score, new_high);
            end
         end
      end
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // Build score to 7, then Reset must clear everything without waiting for a clock edge
   task automatic test_reset_mid_game();
      exp_t e;
      for (int k = 0; k < 14; k++) begin
         if (k > 0 || !q_Play) @(negedge Clk);
         XPipe[9:0] = (k % 2 == 0) ? 10'd100 : 10'd101;
         sbq.push_back(mk($sformatf("mid_step%0d", k), ST_PLAY, k / 2 + 1, 1'b0));
         tick();
         e = sbq.pop_front();
         n_checks++;
         if (obs !== e.val) begin
            n_err++;
            $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                     e.name, obs[20:17], obs[16:1], obs[0], e.val[20:17], e.val[16:1], e.val[0]);
         end else $display("txn %s: st=%b score=%0d col=%b", e.name, obs[20:17], obs[16:1], obs[0]);
      end
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      n_checks++;
      if (obs !== {ST_IDLE, 16'd0, 1'b0} || high_score !== 16'd0 || new_high !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got st=%b score=%0d high=%0d want st=0001 score=0 high=0",
                  obs[20:17], score, high_score);
      end else $display("txn async_reset: st=%b score=%0d high=%0d", obs[20:17], score, high_score);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_fall();
      exp_t e;
      logic [3:0] st_exp;
      logic       col_exp;
`ifdef FLAPPY_FALL_DETECT_EN
      st_exp = ST_DYING; col_exp = 1'b1;
`else
      st_exp = ST_PLAY;  col_exp = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         Start = (k == 0);
         XPipe = {10'd900, 10'd900};
         YBird = 10'd475;
         if (k == 0) sbq.push_back(mk("fall_start", ST_PLAY, 0, 1'b0));
         else        sbq.push_back(mk("fall_floor", st_exp, 0, col_exp));
         tick();
         e = sbq.pop_front();
         n_checks++;
         if (obs !== e.val) begin
            n_err++;
            $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                     e.name, obs[20:17], obs[16:1], obs[0], e.val[20:17], e.val[16:1], e.val[0]);
         end else $display("txn %s: st=%b score=%0d col=%b", e.name, obs[20:17], obs[16:1], obs[0]);
      end
      @(negedge Clk);
      Start = 1'b0;
      Reset = 1'b1;
      YBird = 10'd200;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   // 4-bit score saturates at 15; a later lower game keeps the high score
   task automatic test_saturation();
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         int passes = (g == 0) ? 16 : 3;
         int last   = 2 * passes + 5;
         int sc;
         for (int k = 0; k <= last; k++) begin
            @(negedge Clk);
            Start4 = (k == 0);
            Ack4   = (k == last);
            sc = (passes > 15) ? 15 : passes;
            if (k == 0) begin
               XPipe4[9:0] = 10'd101; YBird4 = 10'd200;
               sbq.push_back(mk($sformatf("sat%0d_start", g), ST_PLAY, 0, 1'b0));
            end else if (k <= 2 * passes) begin
               XPipe4[9:0] = (k % 2 == 1) ? 10'd100 : 10'd101;
               sbq.push_back(mk($sformatf("sat%0d_pass%0d", g, k), ST_PLAY,
                                ((k + 1) / 2 > 15) ? 15 : (k + 1) / 2, 1'b0));
            end else if (k == 2 * passes + 1) begin
               XPipe4[9:0] = 10'd100; YBird4 = 10'd140;
               sbq.push_back(mk($sformatf("sat%0d_hit", g), ST_DYING, sc, 1'b1));
            end else if (k < last - 1) begin
               sbq.push_back(mk($sformatf("sat%0d_dying", g), ST_DYING, sc, 1'b0));
            end else if (k == last - 1) begin
               sbq.push_back(mk($sformatf("sat%0d_over", g), ST_OVER, sc, 1'b0));
            end else begin
               sbq.push_back(mk($sformatf("sat%0d_ack", g), ST_IDLE, 0, 1'b0));
            end
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs4 !== e.val) begin
               n_err++;
               $display("FAIL %s: got st=%b score=%0d col=%b want st=%b score=%0d col=%b",
                        e.name, obs4[20:17], obs4[16:1], obs4[0], e.val[20:17], e.val[16:1], e.val[0]);
            end else $display("txn %s: st=%b score=%0d col=%b", e.name, obs4[20:17], obs4[16:1], obs4[0]);
            if (k == last - 1) begin
               n_checks++;
               if (high_score4 !== 4'd15 || new_high4 !== (g == 0)) begin
                  n_err++;
                  $display("FAIL sat%0d_high: got high=%0d nh=%b want high=15 nh=%b",
                           g, high_score4, new_high4, (g == 0));
               end
            end
         end
      end
      @(negedge Clk);
      Ack4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_scoring();
      test_collision();
      test_double_pass();
      test_reset_mid_game();
      test_fall();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
Parametrised game-flow controller for the Flappy Bird VGA design. It sequences Idle, Play, Dying and Over, and detects bird/pipe collisions across NUM_PIPES pipes. It keeps a saturating score and a session high score. It sits between the input/physics blocks and the renderer, which uses the state flags and scores.

Parameters:
NUM_PIPES, 2, number of pipe channels (1..8)
COORD_W, 10, coordinate width in bits (unsigned pixels)
SCORE_W, 16, score and high-score width
BIRD_HALF, 10, bird half-size in pixels, applied to both X and Y
PIPE_HALF_W, 50, pipe half-width in pixels
GAP_H, 150, vertical gap height; gap spans YPipe..YPipe+GAP_H
DEATH_CYCLES, 60, clock cycles spent in Dying before Over (at least 1)
Y_MAX, 479, floor Y coordinate (used only with FLAPPY_FALL_DETECT_EN)

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  level; leaves Idle
Ack  in  1  level; leaves Over
XBird  in  COORD_W  bird centre X
YBird  in  COORD_W  bird centre Y
XPipe  in  NUM_PIPES*COORD_W  packed pipe centre X; pipe i occupies bits [i*COORD_W +: COORD_W]
YPipe  in  NUM_PIPES*COORD_W  packed top Y of each pipe's gap
q_Idle, q_Play, q_Dying, q_Over  out  1 each  one-hot state flags, registered
collide  out  1  one-cycle pulse on the Play->Dying transition
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score since Reset
new_high  out  1  high in Over when the finished game set a new high score

Behaviour:
- Reset: Reset is asynchronous and active-high; clock is Clk. On Reset: state Idle, score=0, high_score=0, collide=0, new_high=0, death counter=0, all pass flags=0. Reset asserted mid-game aborts immediately with the same values.
- All arithmetic is unsigned and zero-extended to COORD_W+2 bits, so no subtraction can wrap.
- Per-pipe hit, combinational, for pipe i:
  - Horizontal overlap: XBird+BIRD_HALF+PIPE_HALF_W > XPipe_i AND XBird < XPipe_i+PIPE_HALF_W+BIRD_HALF.
  - Vertical miss: YBird < YPipe_i+BIRD_HALF OR YBird+BIRD_HALF > YPipe_i+GAP_H.
  - hit_i = horizontal overlap AND vertical miss.
  - hit_any = OR of all hit_i.
- Pass detection: passed_i = (XBird >= XPipe_i). A new pass on pipe i is passed_i=1 while flag_i=0. flag_i <= passed_i every cycle in Play. flag_i clears automatically when the pipe respawns to the right of the bird.
- State machine, one transition per Clk edge:
  - Idle: score held at 0. On Start: go to Play, score<=0, flag_i<=passed_i, so pipes already left of the bird never score.
  - Play: if hit_any, go to Dying, pulse collide, and award no points that cycle (collision wins over a simultaneous pass). Otherwise score <= score + popcount(new passes); several pipes passed in one cycle each count. Score saturates at 2^SCORE_W-1.
  - Dying: score frozen; counter counts 0..DEATH_CYCLES-1. At DEATH_CYCLES-1, go to Over.
  - Over, on entry: if score > high_score then high_score<=score and new_high<=1; else new_high<=0. On Ack: go to Idle, new_high<=0.
- Start is ignored outside Idle. Ack is ignored outside Over. Start held high through Over->Idle starts a new game on the following cycle.
- Latency: state flags, score and collide all update on the clock edge after the qualifying input.

Optional Feature:
FLAPPY_FALL_DETECT_EN.
- Defined: hit_any additionally includes a floor hit, YBird+BIRD_HALF >= Y_MAX, and a ceiling hit, YBird < BIRD_HALF. Either one enters Dying exactly like a pipe hit.
- Undefined: only pipe hits end a game; the bird may leave the screen vertically without effect.

Test Plan:
- Start, XBird=100, YBird=200, XPipe={900,600}, YPipe={150,150}; ramp pipe 0 X down to 99 -> no collide (bird within gap), score=1 exactly once; pipe 0 X jumps back to 700 -> no extra point.
- Play, XPipe0=100, YPipe0=150, YBird=140 -> next edge q_Dying=1, collide pulses one cycle; after 60 cycles q_Over=1, high_score=1, new_high=1; Ack -> q_Idle.
- Both pipes step from X=101 to X=100 in the same cycle with XBird=100, no hit -> score +2. Same step with a simultaneous hit -> score unchanged, Dying.
- SCORE_W=4, score=15, another pass -> score stays 15. A second game scoring 3 (below high score 15) -> high_score=15, new_high=0.
- Reset asserted for 1 cycle during Play with score=7 -> q_Idle=1, score=0, high_score=0 immediately (asynchronous).
- YBird=475, no pipe overlap: with FLAPPY_FALL_DETECT_EN -> Dying next edge; without it -> stays in Play.
